// File: rtl/aes_dec.sv
// Iterative AES-128 inverse cipher: expands the cipher key forward to K10, then
// runs ten inverse rounds at one per clock while unrolling the key schedule backwards.
module aes_dec (
   input  logic         clk,
   input  logic         rst,
   input  logic         data_valid_in,
   input  logic [127:0] data_in,
   input  logic [127:0] key_in,
   output logic [127:0] res_dec_out,
   output logic         res_valid_out,
   output logic         busy_out
);

   typedef enum logic [1:0] {IDLE, KEYEXP, INIT, ROUND} fsm_e;

   fsm_e         fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [127:0] rkey_q, rkey_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] res_q, res_d;
   logic         vld_q, vld_d;
   logic         busy_q, busy_d;
   logic [127:0] isb;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h00;
      p = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ p;
         p = xt(p);
      end
      return r;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = ginv(x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] c);
      case (c)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] sub_rot(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w3 = k[31:0] ^ k[63:32];
      w2 = k[63:32] ^ k[95:64];
      w1 = k[95:64] ^ k[127:96];
      w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
      return {w0, w1, w2, w3};
   endfunction

   // Byte 4*c+r is row r of column c; row r rotates right by r columns.
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   assign isb = inv_shift_sub(state_q);

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rkey_d  = rkey_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      vld_d   = 1'b0;
      busy_d  = busy_q;
      case (fsm_q)
         IDLE: begin
            if (data_valid_in) begin
               state_d = data_in;
               rkey_d  = key_in;
               cnt_d   = 4'd1;
               busy_d  = 1'b1;
               fsm_d   = KEYEXP;
            end
         end
         KEYEXP: begin
            rkey_d = key_fwd(rkey_q, rcon(cnt_q));
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd10) fsm_d = INIT;
         end
         INIT: begin
            state_d = state_q ^ rkey_q;
            rkey_d  = key_inv(rkey_q, 8'h36);
            cnt_d   = 4'd9;
            fsm_d   = ROUND;
         end
         ROUND: begin
            if (cnt_q != 4'd0) begin
               state_d = inv_mix(isb ^ rkey_q);
               rkey_d  = key_inv(rkey_q, rcon(cnt_q));
               cnt_d   = cnt_q - 4'd1;
            end else begin
               res_d  = isb ^ rkey_q;
               vld_d  = 1'b1;
               busy_d = 1'b0;
               fsm_d  = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         rkey_q  <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rkey_q  <= rkey_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
      end
   end

   assign res_dec_out   = res_q;
   assign res_valid_out = vld_q;
   assign busy_out      = busy_q;

endmodule

// File: tb/tb_aes_dec.sv
// Bench for aes_dec: FIPS-197 vectors, handshake corners, async reset and a
// randomized round trip through a byte-level AES-128 encryption model.
module tb_aes_dec;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         data_valid_in = 1'b0;
   logic [127:0] data_in = '0;
   logic [127:0] key_in = '0;
   logic [127:0] res_dec_out;
   logic         res_valid_out;
   logic         busy_out;

   aes_dec dut (
      .clk(clk), .rst(rst), .data_valid_in(data_valid_in), .data_in(data_in),
      .key_in(key_in), .res_dec_out(res_dec_out), .res_valid_out(res_valid_out),
      .busy_out(busy_out)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   logic [7:0]   sbox [0:255];
   logic [127:0] last_res = '0;

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;
   vec_t vecs [0:2];

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box built by walking generator 3 and its inverse through the field.
   task automatic build_sbox();
      logic [7:0] p, q;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ xt(p);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         sbox[p] = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [7:0] rk [0:175];
      logic [7:0] s [0:15];
      logic [7:0] t [0:15];
      logic [7:0] tmp [0:3];
      logic [7:0] a0, a1, a2, a3, rc, t0;
      logic [127:0] o;
      rc = 8'h01;
      for (int i = 0; i < 16; i++) begin
         rk[i] = key[127-8*i -: 8];
         s[i]  = pt[127-8*i -: 8] ^ rk[i];
      end
      for (int i = 4; i < 44; i++) begin
         for (int j = 0; j < 4; j++) tmp[j] = rk[4*(i-1)+j];
         if (i % 4 == 0) begin
            t0 = tmp[0];
            tmp[0] = sbox[tmp[1]] ^ rc;
            tmp[1] = sbox[tmp[2]];
            tmp[2] = sbox[tmp[3]];
            tmp[3] = sbox[t0];
            rc = xt(rc);
         end
         for (int j = 0; j < 4; j++) rk[4*i+j] = rk[4*(i-4)+j] ^ tmp[j];
      end
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*rnd+i];
      end
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic start(input logic [127:0] k, input logic [127:0] ct);
      @(negedge clk);
      key_in = k;
      data_in = ct;
      data_valid_in = 1'b1;
      @(posedge clk);
      #1;
      chk("busy_after_accept", {127'b0, busy_out}, 128'd1);
      @(negedge clk);
      data_valid_in = 1'b0;
      key_in = rnd128();
      data_in = rnd128();
   endtask

   task automatic wait_res(input logic [127:0] held, output int lat, output logic [127:0] res);
      bit stable;
      stable = 1'b1;
      lat = -1;
      res = '0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (res_valid_out) begin
            lat = n;
            res = res_dec_out;
            chk("busy_low_at_result", {127'b0, busy_out}, 128'd0);
            break;
         end
         if (res_dec_out !== held) stable = 1'b0;
      end
      chk("output_held_while_busy", {127'b0, stable}, 128'd1);
   endtask

   task automatic run_vec(input string tag, input logic [127:0] k, input logic [127:0] ct,
                          input logic [127:0] pt);
      int lat;
      logic [127:0] res;
      start(k, ct);
      wait_res(last_res, lat, res);
      chk({tag, "_latency"}, 128'(lat), 128'd21);
      chk({tag, "_plaintext"}, res, pt);
      @(posedge clk);
      #1;
      chk({tag, "_pulse_single"}, {127'b0, res_valid_out}, 128'd0);
      chk({tag, "_result_held"}, res_dec_out, pt);
      last_res = pt;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] ka, pa, ca, kb, pb, cb, res;
      int pulses, got, lat;

      build_sbox();
      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                  128'h3243f6a8885a308d313198a2e0370734};
      vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

      #3;
      chk("reset_res", res_dec_out, 128'd0);
      chk("reset_valid", {127'b0, res_valid_out}, 128'd0);
      chk("reset_busy", {127'b0, busy_out}, 128'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) run_vec($sformatf("fips%0d", i), vecs[i].key, vecs[i].ct, vecs[i].pt);

      // Strobe held high with changing data during the whole operation.
      ka = rnd128(); pa = rnd128(); ca = aes_enc(ka, pa);
      kb = rnd128(); pb = rnd128(); cb = aes_enc(kb, pb);
      @(negedge clk);
      key_in = ka; data_in = ca; data_valid_in = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_busy_after_accept", {127'b0, busy_out}, 128'd1);
      pulses = 0; got = -1; res = '0;
      for (int n = 1; n <= 21; n++) begin
         @(negedge clk);
         key_in = rnd128(); data_in = rnd128();
         @(posedge clk);
         #1;
         if (res_valid_out) begin
            pulses++;
            got = n;
            res = res_dec_out;
         end
      end
      chk("hold_pulse_count", 128'(pulses), 128'd1);
      chk("hold_latency", 128'(got), 128'd21);
      chk("hold_plaintext", res, pa);
      @(negedge clk);
      key_in = kb; data_in = cb;
      @(posedge clk);
      #1;
      chk("hold_reaccept_busy", {127'b0, busy_out}, 128'd1);
      chk("hold_reaccept_no_pulse", {127'b0, res_valid_out}, 128'd0);
      @(negedge clk);
      data_valid_in = 1'b0;
      wait_res(pa, lat, res);
      chk("hold_second_latency", 128'(lat), 128'd21);
      chk("hold_second_plaintext", res, pb);
      last_res = pb;
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of an operation.
      start(vecs[0].key, vecs[0].ct);
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_res", res_dec_out, 128'd0);
      chk("midrst_valid", {127'b0, res_valid_out}, 128'd0);
      chk("midrst_busy", {127'b0, busy_out}, 128'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk);
         #1;
         if (res_valid_out || busy_out) pulses++;
      end
      chk("midrst_no_activity", 128'(pulses), 128'd0);
      last_res = '0;
      run_vec("post_reset_c1", vecs[0].key, vecs[0].ct, vecs[0].pt);

      for (int i = 0; i < 100; i++) begin
         ka = rnd128();
         pa = rnd128();
         run_vec("roundtrip", ka, aes_enc(ka, pa), pa);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_dec.md
# aes_dec

Iterative AES-128 decryption core, the inverse-cipher counterpart of the `aes` encryption block, sharing its valid-in/valid-out handshake and 128-bit data and key conventions. The block accepts a ciphertext and the original 128-bit cipher key (the same key given to `aes`), derives the final round key internally, then runs ten inverse rounds at one round per clock. It sits beside `aes` on the datapath and shares its test-vector flow (FIPS-197 byte order).

## Interface
- Parameters: none.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `data_valid_in` input 1: start strobe; sampled only in IDLE.
- `data_in` input 128: ciphertext; byte 0 = [127:120], column-major per FIPS-197.
- `key_in` input 128: cipher key (round key 0), same byte order.
- `res_dec_out` output 128: recovered plaintext; registered, held until the next result.
- `res_valid_out` output 1: one-cycle pulse when `res_dec_out` is updated.
- `busy_out` output 1: high from the accept edge until the result edge inclusive; low in IDLE.

## Operation
- Registers: 128-bit `state`, 128-bit `rkey`, 4-bit round/rcon counter, FSM. Rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
- FSM states are IDLE, KEYEXP, INIT, ROUND.
- IDLE: on `data_valid_in`=1, latch `state`<=`data_in` and `rkey`<=`key_in`, set counter=1, and go to KEYEXP.
- KEYEXP (10 cycles): forward key-schedule step `rkey`<=next(rkey, rcon[cnt]) and cnt++. After the 10th step `rkey`=K10. Then go to INIT.
- INIT (1 cycle): `state`<=`state`^K10 and `rkey`<=inverse step(K10, rcon 36)=K9. Set cnt=9 and go to ROUND.
- Inverse key step: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^rcon.
- ROUND, cnt=9..1: `state`<=InvMixColumns(InvSubBytes(InvShiftRows(state))^rkey), `rkey`<=inverse step(rkey, rcon[cnt]), cnt--.
- ROUND, cnt=0: `res_dec_out`<=InvSubBytes(InvShiftRows(state))^K0, with no InvMixColumns. Pulse `res_valid_out` and return to IDLE.
- `data_valid_in` while not IDLE is ignored, with no queuing. `data_in` and `key_in` are only sampled at the accept edge and may change afterwards.
- Forward SubWord uses the S-box; the data path uses the inverse S-box. Both are combinational tables.

## Timing
- E0 is the accept edge (IDLE, `data_valid_in`=1).
- KEYEXP occupies edges E1..E10, INIT is E11, and ROUND runs E12..E21 (K9..K0).
- `res_valid_out`=1 for exactly the cycle after E21, i.e. 21 cycles after E0, and `res_dec_out` is valid from that cycle.
- Earliest next accept edge is E22. Back-to-back throughput is one block per 22 cycles.
- `busy_out` rises after E0 and falls after E21 (goes low with the `res_valid_out` cycle).
- A `data_valid_in` held high through the result cycle is accepted again at E22.
- Reset (async, any time): FSM=IDLE, and `res_dec_out`=0, `res_valid_out`=0, `busy_out`=0 immediately; `state`, `rkey` and cnt are cleared. An in-flight operation is discarded and produces no result pulse after release.
- First accept is possible on the first rising edge with `rst` low.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, `res_valid_out` exactly 21 cycles after accept, single-cycle pulse.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734. Then zero key with ct 66e94bd4ef8a2c3b884cfa59ca342b2e -> all-zero pt.
- Busy drop: hold `data_valid_in` high with changing `data_in` during E1..E21 -> only the E0 block decrypted, exactly one pulse. Held high through the result cycle -> new accept at E22.
- Mid-operation reset: assert `rst` at E8 for 2 cycles -> outputs 0 asynchronously, no pulse afterwards. A fresh C.1 vector then decrypts correctly in 21 cycles.
- Round trip: 100 random key/pt pairs encrypted by `aes` and fed to `aes_dec` -> recovered pt matches, and `res_dec_out` stable between pulses. Also replay the `test_vec/aes_enc_*_hex.txt` files in reverse (res as input, data as expected).
